// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit: FSM state encoding,
// request kinds, watchdog limit and the fixed-priority request arbiter.
package mem_access_unit_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      STORE = 3'd3,
      ERR   = 3'd4
   } mau_state_e;

   typedef enum logic [1:0] {
      KIND_NONE  = 2'd0,
      KIND_FETCH = 2'd1,
      KIND_LOAD  = 2'd2,
      KIND_STORE = 2'd3
   } req_kind_e;

   localparam logic [7:0] MAU_TIMEOUT_LIMIT = 8'd255;

   // Fixed priority fetch > load > store; losing strobes are simply dropped.
   function automatic req_kind_e arbitrate(input logic fetch, input logic rd, input logic wr);
      if (fetch)   return KIND_FETCH;
      else if (rd) return KIND_LOAD;
      else if (wr) return KIND_STORE;
      else         return KIND_NONE;
   endfunction

   function automatic mau_state_e kind_to_state(input req_kind_e kind);
      case (kind)
         KIND_FETCH: return FETCH;
         KIND_LOAD:  return LOAD;
         KIND_STORE: return STORE;
         default:    return IDLE;
      endcase
   endfunction

endpackage

// File: rtl/mau_watchdog.sv
// Bus watchdog for mem_access_unit; only built when MEM_ACCESS_TIMEOUT_EN is defined.
// Counts stalled valid cycles and flags the cycle whose edge reaches the limit.
`ifdef MEM_ACCESS_TIMEOUT_EN
module mau_watchdog
   import mem_access_unit_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (!resetn)    count <= 8'd0;
      else if (clear) count <= 8'd0;
      else if (tick)  count <= count + 8'd1;
   end

   // This stalled cycle is the one that brings the count to the limit.
   assign expired = tick && (count == MAU_TIMEOUT_LIMIT - 8'd1);

endmodule
`endif

// File: rtl/mem_access_unit.sv
// Single-outstanding memory access unit bridging fetch/load/store strobes to a
// valid/ready bus. Optional watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] pc,
   input  logic [31:0] alu_out,
   input  logic [31:0] wdata,
   input  logic        fetch_req,
   input  logic        rd_req,
   input  logic        wr_req,
   output logic        busy,
   output logic        done,
   output logic [31:0] instr,
   output logic [31:0] mdr,
   output logic        mem_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        misaligned,
   output logic        timeout
);

   mau_state_e  state, state_d;
   req_kind_e   req_kind;
   logic [31:0] sel_addr;
   logic        wdog_expired;

   logic        mem_valid_d, mem_we_d, done_d, misaligned_d;
   logic [31:0] mem_addr_d, mem_wdata_d, instr_d, mdr_d;

   assign req_kind = arbitrate(fetch_req, rd_req, wr_req);
   assign sel_addr = (req_kind == KIND_FETCH) ? pc : alu_out;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path can infer a latch.
      state_d      = state;
      mem_valid_d  = mem_valid;
      mem_we_d     = mem_we;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      instr_d      = instr;
      mdr_d        = mdr;
      misaligned_d = misaligned;
      done_d       = 1'b0;

      case (state)
         IDLE: begin
            if (req_kind != KIND_NONE) begin
               if (sel_addr[1:0] != 2'b00) begin
                  state_d      = ERR;
                  misaligned_d = 1'b1;
               end else begin
                  state_d     = kind_to_state(req_kind);
                  mem_valid_d = 1'b1;
                  mem_addr_d  = sel_addr;
                  mem_wdata_d = wdata;
                  mem_we_d    = (req_kind == KIND_STORE);
               end
            end
         end
         FETCH, LOAD, STORE: begin
            if (mem_valid && mem_ready) begin
               if (state == FETCH) instr_d = mem_rdata;
               if (state == LOAD)  mdr_d   = mem_rdata;
               state_d     = IDLE;
               mem_valid_d = 1'b0;
               mem_we_d    = 1'b0;
               done_d      = 1'b1;
            end else if (wdog_expired) begin
               state_d     = ERR;
               mem_valid_d = 1'b0;
               mem_we_d    = 1'b0;
            end
         end
         ERR: ;
         default: state_d = ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous; resetn only acts on a rising clock edge.
      if (!resetn) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         instr      <= 32'd0;
         mdr        <= 32'd0;
         misaligned <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state      <= state_d;
         busy       <= (state_d != IDLE);
         done       <= done_d;
         mem_valid  <= mem_valid_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         instr      <= instr_d;
         mdr        <= mdr_d;
         misaligned <= misaligned_d;
      end
   end

`ifdef MEM_ACCESS_TIMEOUT_EN
   logic wdog_clear, wdog_tick;

   assign wdog_clear = (state == IDLE) && (req_kind != KIND_NONE);
   assign wdog_tick  = mem_valid && !mem_ready;

   mau_watchdog u_watchdog (
      .clk     (clk),
      .resetn  (resetn),
      .clear   (wdog_clear),
      .tick    (wdog_tick),
      .expired (wdog_expired)
   );

   always_ff @(posedge clk) begin
      if (!resetn)           timeout <= 1'b0;
      else if (wdog_expired) timeout <= 1'b1;
   end
`else
   assign wdog_expired = 1'b0;
   assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit: single-cycle-ready vectors
// plus hand-written wait-state, error, reset and watchdog sequences.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] pc, alu_out, wdata, mem_rdata;
   logic        fetch_req, rd_req, wr_req, mem_ready;
   logic        busy, done, mem_valid, mem_we, misaligned, timeout;
   logic [31:0] instr, mdr, mem_addr, mem_wdata;

   int checks = 0;
   int errors = 0;

   mem_access_unit dut (
      .clk        (clk),
      .resetn     (resetn),
      .pc         (pc),
      .alu_out    (alu_out),
      .wdata      (wdata),
      .fetch_req  (fetch_req),
      .rd_req     (rd_req),
      .wr_req     (wr_req),
      .busy       (busy),
      .done       (done),
      .instr      (instr),
      .mdr        (mdr),
      .mem_valid  (mem_valid),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .misaligned (misaligned),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        f, r, w;
      logic [31:0] pc, alu, wdata, rdata;
      logic        exp_mis, exp_we;
      logic [31:0] exp_addr, exp_instr, exp_mdr;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      fetch_req = 1'b0;
      rd_req    = 1'b0;
      wr_req    = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      //           f  r  w   pc            alu           wdata         rdata         mis we  addr          instr         mdr
      vecs[0] = '{1, 0, 0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 32'h0050_0093, 0, 0, 32'h0000_0100, 32'h0050_0093, 32'h0000_0000};
      vecs[1] = '{0, 1, 0, 32'h0000_0000, 32'h0000_2008, 32'h0000_0000, 32'h1122_3344, 0, 0, 32'h0000_2008, 32'h0050_0093, 32'h1122_3344};
      vecs[2] = '{0, 0, 1, 32'h0000_0000, 32'h0000_300C, 32'hCAFE_F00D, 32'h5555_5555, 0, 1, 32'h0000_300C, 32'h0050_0093, 32'h1122_3344};
      vecs[3] = '{1, 1, 0, 32'h0000_0104, 32'h0000_2000, 32'h0000_0000, 32'h00A0_0113, 0, 0, 32'h0000_0104, 32'h00A0_0113, 32'h1122_3344};
      vecs[4] = '{0, 1, 1, 32'h0000_0000, 32'h0000_2010, 32'h0000_0001, 32'h0BAD_F00D, 0, 0, 32'h0000_2010, 32'h00A0_0113, 32'h0BAD_F00D};
      vecs[5] = '{1, 1, 1, 32'h0000_0108, 32'h0000_2014, 32'h0000_0002, 32'h1234_5678, 0, 0, 32'h0000_0108, 32'h1234_5678, 32'h0BAD_F00D};
      vecs[6] = '{1, 1, 0, 32'h0000_0103, 32'h0000_2000, 32'h0000_0000, 32'h0000_0000, 1, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      vecs[7] = '{0, 1, 0, 32'h0000_0000, 32'h0000_2001, 32'h0000_0000, 32'h0000_0000, 1, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

      clear_reqs();
      pc = 32'd0; alu_out = 32'd0; wdata = 32'd0;
      mem_ready = 1'b0; mem_rdata = 32'd0;
      do_reset();

      check("rst_state_idle", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_we", {31'd0, mem_we}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_mdr", mdr, 32'd0);
      check("rst_misaligned", {31'd0, misaligned}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         if (i == 6) begin
            // Load with three wait states: address must hold while alu_out moves.
            alu_out = 32'h0000_2004; rd_req = 1'b1; mem_ready = 1'b0;
            tick();
            clear_reqs();
            alu_out = 32'hFFFF_FFF0;
            check("wait_valid_1", {31'd0, mem_valid}, 32'd1);
            check("wait_addr_1", mem_addr, 32'h0000_2004);
            for (int k = 2; k <= 4; k++) begin
               tick();
               check($sformatf("wait_valid_%0d", k), {31'd0, mem_valid}, 32'd1);
               check($sformatf("wait_addr_%0d", k), mem_addr, 32'h0000_2004);
               check($sformatf("wait_done_%0d", k), {31'd0, done}, 32'd0);
            end
            mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
            tick();
            mem_ready = 1'b0;
            check("wait_valid_end", {31'd0, mem_valid}, 32'd0);
            check("wait_done", {31'd0, done}, 32'd1);
            check("wait_mdr", mdr, 32'hDEAD_BEEF);
            check("wait_instr_kept", instr, 32'h1234_5678);
            tick();
         end

         fetch_req = vecs[i].f; rd_req = vecs[i].r; wr_req = vecs[i].w;
         pc = vecs[i].pc; alu_out = vecs[i].alu; wdata = vecs[i].wdata;
         mem_ready = 1'b1; mem_rdata = vecs[i].rdata;
         tick();
         clear_reqs();
         if (vecs[i].exp_mis) begin
            check($sformatf("v%0d_misaligned", i), {31'd0, misaligned}, 32'd1);
            check($sformatf("v%0d_valid", i), {31'd0, mem_valid}, 32'd0);
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            tick();
            check($sformatf("v%0d_valid_err", i), {31'd0, mem_valid}, 32'd0);
            check($sformatf("v%0d_done_err", i), {31'd0, done}, 32'd0);
            mem_ready = 1'b0;
            do_reset();
            check($sformatf("v%0d_mis_cleared", i), {31'd0, misaligned}, 32'd0);
         end else begin
            check($sformatf("v%0d_valid", i), {31'd0, mem_valid}, 32'd1);
            check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_we", i), {31'd0, mem_we}, {31'd0, vecs[i].exp_we});
            if (vecs[i].exp_we) check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wdata);
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            check($sformatf("v%0d_done_early", i), {31'd0, done}, 32'd0);
            tick();
            check($sformatf("v%0d_valid_end", i), {31'd0, mem_valid}, 32'd0);
            check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
            check($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_instr", i), instr, vecs[i].exp_instr);
            check($sformatf("v%0d_mdr", i), mdr, vecs[i].exp_mdr);
            tick();
            check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_idle_valid", i), {31'd0, mem_valid}, 32'd0);
         end
      end

      // Misaligned store parks in ERR and ignores further requests and ready.
      mem_ready = 1'b0;
      alu_out = 32'h0000_2002; wdata = 32'hAAAA_5555; wr_req = 1'b1;
      tick();
      clear_reqs();
      check("mst_misaligned", {31'd0, misaligned}, 32'd1);
      check("mst_valid", {31'd0, mem_valid}, 32'd0);
      fetch_req = 1'b1; pc = 32'h0000_0200; mem_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("mst_hold_valid_%0d", k), {31'd0, mem_valid}, 32'd0);
         check($sformatf("mst_hold_busy_%0d", k), {31'd0, busy}, 32'd1);
         check($sformatf("mst_hold_done_%0d", k), {31'd0, done}, 32'd0);
      end
      clear_reqs();
      mem_ready = 1'b0;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("mst_rst_busy", {31'd0, busy}, 32'd0);
      check("mst_rst_misaligned", {31'd0, misaligned}, 32'd0);

      // Reset on the second valid cycle of a load aborts it without capture.
      alu_out = 32'h0000_2020; rd_req = 1'b1;
      tick();
      clear_reqs();
      check("rml_valid_1", {31'd0, mem_valid}, 32'd1);
      tick();
      check("rml_valid_2", {31'd0, mem_valid}, 32'd1);
      resetn = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      check("rml_valid_drop", {31'd0, mem_valid}, 32'd0);
      check("rml_mdr", mdr, 32'd0);
      check("rml_done", {31'd0, done}, 32'd0);
      check("rml_busy", {31'd0, busy}, 32'd0);
      resetn = 1'b1;
      tick();
      check("rml_done_after", {31'd0, done}, 32'd0);
      check("rml_mdr_after", mdr, 32'd0);
      mem_ready = 1'b0;

      // Bus that never answers.
      alu_out = 32'h0000_2040; rd_req = 1'b1;
      tick();
      clear_reqs();
`ifdef MEM_ACCESS_TIMEOUT_EN
      begin
         int n = 0;
         while (mem_valid && n < 400) begin
            n++;
            tick();
         end
         check("to_valid_cycles", n, 32'd255);
         check("to_valid", {31'd0, mem_valid}, 32'd0);
         check("to_timeout", {31'd0, timeout}, 32'd1);
         check("to_busy_err", {31'd0, busy}, 32'd1);
         tick();
         check("to_done", {31'd0, done}, 32'd0);
      end
`else
      repeat (1000) tick();
      check("nto_valid", {31'd0, mem_valid}, 32'd1);
      check("nto_addr", mem_addr, 32'h0000_2040);
      check("nto_timeout", {31'd0, timeout}, 32'd0);
      check("nto_busy", {31'd0, busy}, 32'd1);
`endif
      do_reset();
      check("final_idle", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 pc  in  32  instruction fetch address.
REQ-004 alu_out  in  32  load/store data address.
REQ-005 wdata  in  32  store data.
REQ-006 fetch_req, rd_req, wr_req  in  1 each  request strobes: instruction fetch, load, store.
REQ-007 busy  out  1  high while a transaction is outstanding; the control FSM stalls on it.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 instr  out  32  instruction register; mdr  out  32  memory data register.
REQ-010 mem_valid  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32  bus request side.
REQ-011 mem_ready  in  1; mem_rdata  in  32  bus response side.
REQ-012 misaligned  out  1  sticky alignment error; timeout  out  1  sticky watchdog error.

Function
REQ-013 FSM states SHALL be IDLE, FETCH, LOAD, STORE and ERR.
REQ-014 Requests SHALL be sampled only in IDLE; requests in other states SHALL be ignored.
REQ-015 Simultaneous requests SHALL be resolved fetch > load > store; the losers are dropped.
REQ-016 On accept, mem_addr (pc for fetch, alu_out for load/store), mem_wdata and mem_we (1 only for store) SHALL be registered, and mem_valid SHALL rise on the next cycle.
REQ-017 mem_valid, mem_addr, mem_wdata and mem_we SHALL hold stable until the cycle in which mem_ready is sampled high.
REQ-018 In the mem_ready cycle: FETCH SHALL capture mem_rdata into instr, and LOAD SHALL capture it into mdr.
REQ-019 In the cycle after mem_ready, the FSM SHALL be in IDLE, mem_valid=0, done=1, and the captured data visible.
REQ-020 With mem_ready=1 on the first valid cycle, request to done SHALL take exactly 2 cycles.
REQ-021 busy SHALL equal (state is not IDLE), registered; busy SHALL be 0 in the done cycle.
REQ-022 The alignment check is address[1:0]!=0 on the selected address. A misaligned request SHALL NOT issue mem_valid, SHALL enter ERR and SHALL set misaligned.
REQ-023 ERR SHALL be absorbing: busy=1, no bus activity, no done, exit only by reset.
REQ-024 instr and mdr SHALL hold their values between captures; a store SHALL modify neither.
REQ-025 A mem_ready that arrives while mem_valid=0 SHALL be ignored.

Reset
REQ-026 Reset SHALL give: state=IDLE, busy=0, done=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, instr=0, mdr=0, misaligned=0, timeout=0.
REQ-027 Reset during an outstanding transaction SHALL drop mem_valid at that edge with no capture and no done.

Configuration
REQ-028 Macro MEM_ACCESS_TIMEOUT_EN, when defined, SHALL add an 8-bit watchdog:
- clears on accept;
- increments each cycle that mem_valid=1 and mem_ready=0;
- on reaching 255, SHALL drop mem_valid, set timeout and enter ERR.
REQ-029 When MEM_ACCESS_TIMEOUT_EN is undefined, the unit SHALL wait indefinitely and timeout SHALL be tied 0; the port list SHALL stay unchanged.

Structure
REQ-030 A shared package SHALL hold the state encoding (3-bit), the MAU_TIMEOUT_LIMIT=255 constant and the request-kind enum (FETCH/LOAD/STORE).
REQ-031 The watchdog SHALL be sub-module mau_watchdog, instantiated only under MEM_ACCESS_TIMEOUT_EN; everything else is flat.

Verification
REQ-032 Fetch: pc=0x100, mem_ready held 1, mem_rdata=0x00500093 -> mem_valid for 1 cycle at addr 0x100; instr=0x00500093 and done=1 two cycles after request.
REQ-033 Load with 3 wait cycles: alu_out=0x2004, mem_ready on the 4th valid cycle, rdata=0xDEADBEEF -> mem_valid high 4 cycles with stable addr; mdr=0xDEADBEEF; instr unchanged.
REQ-034 Simultaneous requests: fetch_req=rd_req=1 -> only the fetch is issued (mem_we=0, addr=pc); the load is never issued.
REQ-035 Misaligned store: alu_out=0x2002, wr_req=1 -> mem_valid never rises; misaligned=1; busy=1 until resetn=0.
REQ-036 Reset mid-load: resetn=0 on the 2nd valid cycle -> mem_valid=0 next cycle; mdr=0; no done pulse.
REQ-037 Timeout (MEM_ACCESS_TIMEOUT_EN defined): mem_ready held 0 -> after 255 valid cycles, mem_valid=0, timeout=1, state ERR. Same stimulus with the macro undefined -> mem_valid still 1 after 1000 cycles.
